motor_cmd_sched: RTL

- Frame-synchronous scheduler that owns the MC1/MC2 commands feeding the dual-motor pulse generator.
- Arbitrates between two requesters, navigation (low priority) and obstacle avoidance (high priority), plus an emergency stop.
- Slew-limits each motor one power step per 12 ms refresh frame and forces a neutral dwell on direction reversal.
- Commands change only on frame boundaries, so the pulse generator never sees a mid-frame update.

---
 rtl/motor_cmd_sched.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/motor_cmd_sched.sv
// Frame-synchronous MC1/MC2 command scheduler: arbitrates navigation versus
// obstacle avoidance, handles emergency stop, and slew-limits each motor one
// power step per refresh frame with a neutral dwell on direction reversal.
module motor_cmd_sched #(
  parameter int unsigned REFRESH        = 1200000,
  parameter int unsigned NEUTRAL_FRAMES = 2,
  parameter int unsigned OBS_HOLD       = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_estop,
  input  logic       i_nav_req,
  input  logic [4:0] i_nav_mc1,
  input  logic [4:0] i_nav_mc2,
  input  logic       i_obs_req,
  input  logic [4:0] i_obs_mc1,
  input  logic [4:0] i_obs_mc2,
  output logic [4:0] o_mc1,
  output logic [4:0] o_mc2,
  output logic       o_grant_nav,
  output logic       o_grant_obs,
  output logic       o_frame,
  output logic       o_at_target
);

  localparam int unsigned CNT_W  = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int unsigned DW_W   = (NEUTRAL_FRAMES > 0) ? $clog2(NEUTRAL_FRAMES + 1) : 1;
  localparam int unsigned HOLD_W = (OBS_HOLD > 0) ? $clog2(OBS_HOLD + 1) : 1;
  localparam int unsigned RMP_W  = 5 + DW_W + 1;
  localparam logic [4:0]  MC_NEUTRAL = 5'b00001;

  typedef enum logic [1:0] {ST_IDLE, ST_NAV, ST_OBS, ST_STOP} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_frame;
  logic [HOLD_W-1:0]  r_hold;
  logic signed [4:0]  r_cur1, r_cur2;
  logic signed [4:0]  r_tgt1, r_tgt2;
  logic [DW_W-1:0]    r_dw1, r_dw2;
  logic               r_neg1, r_neg2;
  logic [4:0]         r_mc1, r_mc2;
  logic               r_grant_nav, r_grant_obs, r_at;

  state_t             w_state_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic signed [4:0]  w_tgt1, w_tgt2;
  logic signed [4:0]  w_cur1, w_cur2;
  logic [DW_W-1:0]    w_dw1, w_dw2;
  logic               w_neg1, w_neg2;
  logic               w_at;

  // MC command -> signed speed (-8..+8); 01 and 11 both mean neutral
  function automatic logic signed [4:0] f_dec(input logic [4:0] cmd);
    logic signed [4:0] mag;
    mag = $signed({2'b00, cmd[4:2]}) + 5'sd1;
    case (cmd[1:0])
      2'b00:   return mag;
      2'b10:   return -mag;
      default: return 5'sd0;
    endcase
  endfunction

  // Signed speed -> MC command
  function automatic logic [4:0] f_enc(input logic signed [4:0] s);
    logic [4:0] a;
    if (s == 5'sd0) return MC_NEUTRAL;
    a = s[4] ? 5'(-s) : 5'(s);
    return {3'(a - 5'd1), (s[4] ? 2'b10 : 2'b00)};
  endfunction

  // One frame of slew limiting for a single motor: returns {speed, dwell, last_neg}
  function automatic logic [RMP_W-1:0] f_ramp(input logic signed [4:0] cur,
                                               input logic signed [4:0] tgt,
                                               input logic [DW_W-1:0]   dw,
                                               input logic              neg);
    logic signed [4:0] c;
    logic [DW_W-1:0]   d;
    logic              n;
    c = cur;
    d = dw;
    n = neg;
    if (cur != 5'sd0) begin
      if (tgt > cur)      c = cur + 5'sd1;
      else if (tgt < cur) c = cur - 5'sd1;
      if (c == 5'sd0) begin
        d = DW_W'(NEUTRAL_FRAMES);
        n = cur[4];
      end else begin
        d = '0;
      end
    end else if (tgt != 5'sd0) begin
      // Reversal waits out the dwell; same-direction restart goes at once
      if ((d != '0) && (tgt[4] != neg)) begin
        d = d - DW_W'(1);
      end else begin
        c = tgt[4] ? -5'sd1 : 5'sd1;
        d = '0;
      end
    end else if (d != '0) begin
      d = d - DW_W'(1);
    end
    return {c, d, n};
  endfunction

  // Arbitration decision applied at the next frame boundary
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_STOP: w_state_nxt = ST_IDLE;
      ST_OBS: begin
        if (i_obs_req) begin
          w_hold_nxt = HOLD_W'(OBS_HOLD);
        end else if (r_hold == '0) begin
          w_state_nxt = i_nav_req ? ST_NAV : ST_IDLE;
        end else begin
          w_hold_nxt = r_hold - HOLD_W'(1);
        end
      end
      default: begin
        if (i_obs_req) begin
          w_state_nxt = ST_OBS;
          w_hold_nxt  = HOLD_W'(OBS_HOLD);
        end else if (i_nav_req) begin
          w_state_nxt = ST_NAV;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Targets follow the owner selected at this frame
  always_comb begin
    w_tgt1 = 5'sd0;
    w_tgt2 = 5'sd0;
    case (w_state_nxt)
      ST_NAV: begin
        w_tgt1 = f_dec(i_nav_mc1);
        w_tgt2 = f_dec(i_nav_mc2);
      end
      ST_OBS: begin
        w_tgt1 = f_dec(i_obs_mc1);
        w_tgt2 = f_dec(i_obs_mc2);
      end
      default: ;
    endcase
  end

  // Per-motor ramp results and the settled flag they imply
  always_comb begin
    {w_cur1, w_dw1, w_neg1} = f_ramp(r_cur1, w_tgt1, r_dw1, r_neg1);
    {w_cur2, w_dw2, w_neg2} = f_ramp(r_cur2, w_tgt2, r_dw2, r_neg2);
    w_at = (w_cur1 == w_tgt1) && (w_cur2 == w_tgt2) &&
           (w_dw1 == '0) && (w_dw2 == '0);
  end

  // Frame counter, arbiter state and command registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_frame     <= 1'b0;
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_cur1      <= 5'sd0;
      r_cur2      <= 5'sd0;
      r_tgt1      <= 5'sd0;
      r_tgt2      <= 5'sd0;
      r_dw1       <= '0;
      r_dw2       <= '0;
      r_neg1      <= 1'b0;
      r_neg2      <= 1'b0;
      r_mc1       <= MC_NEUTRAL;
      r_mc2       <= MC_NEUTRAL;
      r_grant_nav <= 1'b0;
      r_grant_obs <= 1'b0;
      r_at        <= 1'b1;
    end else begin
      r_cnt   <= (r_cnt == CNT_W'(REFRESH - 1)) ? '0 : r_cnt + CNT_W'(1);
      // Registered so that it is high exactly while the counter sits at REFRESH-1
      r_frame <= (r_cnt == CNT_W'(REFRESH - 2));
      if (i_estop) begin
        r_state     <= ST_STOP;
        r_hold      <= '0;
        r_cur1      <= 5'sd0;
        r_cur2      <= 5'sd0;
        r_tgt1      <= 5'sd0;
        r_tgt2      <= 5'sd0;
        r_dw1       <= '0;
        r_dw2       <= '0;
        r_mc1       <= MC_NEUTRAL;
        r_mc2       <= MC_NEUTRAL;
        r_grant_nav <= 1'b0;
        r_grant_obs <= 1'b0;
        r_at        <= 1'b1;
      end else if (r_frame) begin
        r_state     <= w_state_nxt;
        r_hold      <= w_hold_nxt;
        r_cur1      <= w_cur1;
        r_cur2      <= w_cur2;
        r_tgt1      <= w_tgt1;
        r_tgt2      <= w_tgt2;
        r_dw1       <= w_dw1;
        r_dw2       <= w_dw2;
        r_neg1      <= w_neg1;
        r_neg2      <= w_neg2;
        r_mc1       <= f_enc(w_cur1);
        r_mc2       <= f_enc(w_cur2);
        r_grant_nav <= (w_state_nxt == ST_NAV);
        r_grant_obs <= (w_state_nxt == ST_OBS);
        r_at        <= w_at;
      end
    end
  end

  assign o_mc1       = r_mc1;
  assign o_mc2       = r_mc2;
  assign o_grant_nav = r_grant_nav;
  assign o_grant_obs = r_grant_obs;
  assign o_frame     = r_frame;
  assign o_at_target = r_at;

endmodule
